// File: rtl/mem_ctrl.sv
// Cache-line memory controller: one outstanding line fill or writeback at a time,
// with fixed request-phase and response-phase latencies around a word-organised array.
module mem_ctrl #(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int CACHE_LINE_WIDTH = 128,
  parameter int MEM_DEPTH        = 8192,
  parameter int REQ_DELAY        = 5,
  parameter int RESP_DELAY       = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_write_i,
  input  logic [ADDRESS_WIDTH-1:0]    req_addr_i,
  input  logic [CACHE_LINE_WIDTH-1:0] req_data_i,
  output logic                        resp_valid_o,
  output logic [CACHE_LINE_WIDTH-1:0] resp_data_o
);

  localparam int WORDS     = 4;
  localparam int MAX_DELAY = (REQ_DELAY > RESP_DELAY) ? REQ_DELAY : RESP_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY + 1);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDRESS_WIDTH-3:0] DEPTH_W = (ADDRESS_WIDTH-2)'(MEM_DEPTH);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_REQ_WAIT  = 2'd1;
  localparam logic [1:0] S_RESP_WAIT = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        resp_valid_q, resp_valid_d;
  logic [CACHE_LINE_WIDTH-1:0] resp_data_q, resp_data_d;

  logic                        write_q;
  logic [ADDRESS_WIDTH-5:0]    line_q;
  logic [CACHE_LINE_WIDTH-1:0] wdata_q;

  logic [31:0] mem_q [MEM_DEPTH];

  logic                       accept;
  logic                       access;
  logic [ADDRESS_WIDTH-3:0]   word_addr;
  logic [IDX_W-1:0]           base_idx;
  logic                       unused_addr_bits;

  assign accept           = req_valid_i && (state_q == S_IDLE);
  assign access           = (state_q == S_REQ_WAIT) && (cnt_q == '0);
  // The two low byte-offset bits and the word-in-line bits are dropped: lines are aligned by truncation.
  assign word_addr        = {line_q, 2'b00};
  assign base_idx         = IDX_W'(word_addr % DEPTH_W);
  assign unused_addr_bits = ^req_addr_i[3:0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_REQ_WAIT;
          cnt_d   = CNT_W'(REQ_DELAY - 1);
        end
      end
      S_REQ_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP_WAIT;
          cnt_d   = CNT_W'(RESP_DELAY - 1);
          if (!write_q) begin
            for (int k = 0; k < WORDS; k++) begin
              resp_data_d[32*k +: 32] = mem_q[base_idx + IDX_W'(k)];
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Request fields are captured only at acceptance so later input changes cannot disturb the request.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write_i;
      line_q  <= req_addr_i[ADDRESS_WIDTH-1:4];
      wdata_q <= req_data_i;
    end
  end

  // Storage is deliberately outside the reset domain so committed writes survive a reset.
  always_ff @(posedge clk) begin
    if (access && write_q) begin
      for (int k = 0; k < WORDS; k++) begin
        mem_q[base_idx + IDX_W'(k)] <= wdata_q[32*k +: 32];
      end
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl against a word-array reference model.
module tb_mem_ctrl;

  localparam int AW    = 32;
  localparam int CLW   = 128;
  localparam int DEPTH = 8192;
  localparam int RQD   = 5;
  localparam int RSD   = 5;
  localparam int LAT   = RQD + RSD;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid_i;
  logic           req_ready_o;
  logic           req_write_i;
  logic [AW-1:0]  req_addr_i;
  logic [CLW-1:0] req_data_i;
  logic           resp_valid_o;
  logic [CLW-1:0] resp_data_o;

  always #5 clk = ~clk;

  mem_ctrl #(
    .ADDRESS_WIDTH   (AW),
    .CACHE_LINE_WIDTH(CLW),
    .MEM_DEPTH       (DEPTH),
    .REQ_DELAY       (RQD),
    .RESP_DELAY      (RSD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .resp_valid_o(resp_valid_o),
    .resp_data_o (resp_data_o)
  );

  logic [31:0]  ref_mem [DEPTH];
  logic [127:0] ref_resp;
  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Line base as a word number: byte address / 16 lines, 4 words per line, wrapped into the array.
  function automatic int line_base(input logic [31:0] a);
    return int'(((a / 32'd16) * 32'd4) % 32'(DEPTH));
  endfunction

  function automatic logic [127:0] ref_line(input int b);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic ref_write(input int b, input logic [127:0] d);
    for (int k = 0; k < 4; k++) ref_mem[b+k] = d[32*k +: 32];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [127:0] data,
                        input logic scramble);
    int n;
    logic seen_ready;
    logic [127:0] exp;
    check("ready_before_req", 128'(req_ready_o), 128'(1));
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_data_i  = data;
    step();
    req_valid_i = 1'b0;
    if (wr) begin
      ref_write(line_base(addr), data);
      exp = ref_resp;
    end else begin
      exp      = ref_line(line_base(addr));
      ref_resp = exp;
    end
    n = 0;
    seen_ready = 1'b0;
    do begin
      if (scramble) begin
        req_addr_i  = $urandom;
        req_data_i  = {$urandom, $urandom, $urandom, $urandom};
        req_write_i = 1'($urandom);
      end
      step();
      n++;
      if (!resp_valid_o && req_ready_o) seen_ready = 1'b1;
    end while (!resp_valid_o && n < LAT + 8);
    check("latency", 128'(n), 128'(LAT));
    check("ready_low_in_flight", 128'(seen_ready), 128'(0));
    check("ready_at_resp", 128'(req_ready_o), 128'(1));
    check(wr ? "wr_ack_data_hold" : "fill_data", resp_data_o, exp);
    step();
    check("resp_one_cycle", 128'(resp_valid_o), 128'(0));
  endtask

  task automatic back_to_back();
    logic [31:0]  a   [3];
    logic [127:0] exp [3];
    int p [3];
    int np, t;
    logic do_next, do_drop;
    for (int i = 0; i < 3; i++) begin
      a[i]   = $urandom & 32'h0000_FFF0;
      exp[i] = ref_line(line_base(a[i]));
      p[i]   = 0;
    end
    np = 0;
    t  = 0;
    do_next = 1'b0;
    do_drop = 1'b0;
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = a[0];
    step();
    req_addr_i = a[1];
    while (np < 3 && t < 4 * LAT) begin
      step();
      t++;
      if (do_next) begin req_addr_i = a[2]; do_next = 1'b0; end
      if (do_drop) begin req_valid_i = 1'b0; do_drop = 1'b0; end
      if (resp_valid_o) begin
        p[np] = t;
        check("b2b_data", resp_data_o, exp[np]);
        check("b2b_ready_at_pulse", 128'(req_ready_o), 128'(1));
        np++;
        if (np == 1) do_next = 1'b1;
        if (np == 2) do_drop = 1'b1;
      end
    end
    // Acceptance happens at the edge that closes the pulse cycle, so each line takes LAT+1 edges.
    check("b2b_pulses", 128'(np), 128'(3));
    check("b2b_first", 128'(p[0]), 128'(LAT));
    check("b2b_gap1", 128'(p[1] - p[0]), 128'(LAT + 1));
    check("b2b_gap2", 128'(p[2] - p[1]), 128'(LAT + 1));
    ref_resp = exp[2];
    step();
    check("b2b_idle", 128'({resp_valid_o, req_ready_o}), 128'(2'b01));
  endtask

  task automatic reset_mid(input int k, input logic [31:0] addr, input logic [127:0] data);
    logic seen;
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = addr;
    req_data_i  = data;
    step();
    req_valid_i = 1'b0;
    for (int i = 0; i < k; i++) step();
    reset = 1'b1;
    #1;
    check("rst_ready", 128'(req_ready_o), 128'(1));
    check("rst_resp_valid", 128'(resp_valid_o), 128'(0));
    check("rst_resp_data", resp_data_o, 128'(0));
    step();
    reset = 1'b0;
    if (k >= RQD) ref_write(line_base(addr), data);
    ref_resp = '0;
    seen = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      if (resp_valid_o) seen = 1'b1;
    end
    check("rst_no_pulse", 128'(seen), 128'(0));
    do_txn(1'b0, addr, '0, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    reset       = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
    ref_resp    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      a = $urandom;
      dut.mem_q[i] = a;
      ref_mem[i]   = a;
    end
    for (int i = 0; i < 4; i++) begin
      a = 32'h11 * (i + 1);
      dut.mem_q[32'h400 + i] = a;
      ref_mem[32'h400 + i]   = a;
    end
    #2;
    check("reset_ready", 128'(req_ready_o), 128'(1));
    check("reset_resp_valid", 128'(resp_valid_o), 128'(0));
    check("reset_resp_data", resp_data_o, 128'(0));
    step();
    step();
    reset = 1'b0;
    step();

    do_txn(1'b0, 32'h1000, '0, 1'b0);
    check("fill_const", resp_data_o, 128'h00000044_00000033_00000022_00000011);

    do_txn(1'b1, 32'h4000, 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF, 1'b0);
    check("wr_ack_keeps_fill", resp_data_o, 128'h00000044_00000033_00000022_00000011);
    do_txn(1'b0, 32'h4008, '0, 1'b0);
    check("wb_fill_const", resp_data_o, 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF);

    do_txn(1'b1, 32'h8000, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    do_txn(1'b0, 32'h0000, '0, 1'b0);

    back_to_back();

    reset_mid(3, 32'h100, 128'hA5A5A5A5_5A5A5A5A_F00DF00D_0BADC0DE);
    reset_mid(7, 32'h100, 128'h11112222_33334444_55556666_77778888);

    do_txn(1'b1, 32'h2340, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    do_txn(1'b0, 32'h2340, '0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_03FF) : $urandom;
      do_txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom},
             1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule
